mem_bus_arbiter: RTL and testbench

- Shares one 32-bit memory bus between the IF stage's instruction fetch port and the MEM stage's data port, which carries loads, stores, LL and SC.
- Drives multi-cycle request/ack transactions on the bus and holds each result in a register until the owning pipeline stage advances.
- Raises per-stage stall requests toward the pipeline control block.
- MEM is the older instruction, so it always wins over IF.

---
 rtl/mem_bus_arbiter_if.sv | 14 +
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory bus bundle between the IF/MEM arbiter (master) and the memory system (slave).
interface mem_bus_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        timeout;

  modport master (output req, we, addr, sel, wdata, timeout, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, timeout, output rdata, ack);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one 32-bit request/ack memory bus between the IF fetch port and the MEM data port.
// MEM always wins; results are held until the owning stage advances.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               if_ce_i,
  input  logic [31:0]        if_addr_i,
  input  logic               if_hold_i,
  output logic [31:0]        if_data_o,
  output logic               if_stallreq_o,
  input  logic               mem_ce_i,
  input  logic               mem_we_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [3:0]         mem_sel_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic               mem_hold_i,
  output logic [31:0]        mem_rdata_o,
  output logic               mem_stallreq_o,
  mem_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, DATA, INST, DRAIN} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic        mem_pend, if_pend;
  logic        hit, tmo, done_ev;
  logic [31:0] rdata_eff;
  logic        mem_set, if_set;

  assign mem_pend  = mem_ce_i & ~mem_done_q;
  assign if_pend   = if_ce_i & ~if_done_q;

  // req_q is only ever high outside IDLE, so an ack seen in IDLE is ignored here.
  assign hit       = req_q & bus.ack;
  assign tmo       = (TIMEOUT != 0) && req_q && !bus.ack && (cnt_q == TMO_LAST);
  assign done_ev   = hit | tmo;
  assign rdata_eff = tmo ? 32'h0 : bus.rdata;

  assign mem_set   = (state_q == DATA) & done_ev & ~flush_i;
  assign if_set    = (state_q == INST) & done_ev & ~flush_i;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (mem_pend) begin
            state_d = DATA;
            req_d   = 1'b1;
            we_d    = mem_we_i;
            addr_d  = mem_addr_i;
            sel_d   = mem_sel_i;
            wdata_d = mem_wdata_i;
            cnt_d   = 8'h0;
          end else if (if_pend) begin
            state_d = INST;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            sel_d   = 4'b1111;
            cnt_d   = 8'h0;
          end
        end
      end
      DATA, INST, DRAIN: begin
        tmo_d = tmo;
        if (done_ev) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (mem_set && !we_q) mem_rdata_d = rdata_eff;
          if (if_set)           if_data_d   = rdata_eff;
        end else begin
          cnt_d = cnt_q + 8'h1;
          // A flushed access keeps the bus request up so an issued write still lands.
          if (flush_i) state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A done flag survives a held stage; its own ack beats the clear, flush beats both.
  always_comb begin
    mem_done_d = mem_done_q;
    if_done_d  = if_done_q;
    if (flush_i)          mem_done_d = 1'b0;
    else if (mem_set)     mem_done_d = 1'b1;
    else if (!mem_hold_i) mem_done_d = 1'b0;
    if (flush_i)          if_done_d  = 1'b0;
    else if (if_set)      if_done_d  = 1'b1;
    else if (!if_hold_i)  if_done_d  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      sel_q       <= 4'b0000;
      wdata_q     <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      cnt_q       <= 8'h0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.req        = req_q;
  assign bus.we         = we_q;
  assign bus.addr       = addr_q;
  assign bus.sel        = sel_q;
  assign bus.wdata      = wdata_q;
  assign bus.timeout    = tmo_q;
  assign if_data_o      = if_data_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign if_stallreq_o  = if_pend;
  assign mem_stallreq_o = mem_pend;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, arbitration, held store, flush drain, timeout, reset.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        if_ce_i, if_hold_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i, mem_we_i, mem_hold_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        mem_stallreq_o;

  int nvec = 0;
  int nerr = 0;
  int wr_cnt = 0;
  int wr0;

  mem_bus_arbiter_if b();

  mem_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_hold_i(if_hold_i),
    .if_data_o(if_data_o), .if_stallreq_o(if_stallreq_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i), .mem_hold_i(mem_hold_i),
    .mem_rdata_o(mem_rdata_o), .mem_stallreq_o(mem_stallreq_o),
    .bus(b)
  );

  always #5 clk = ~clk;

  // Count bus writes that actually complete.
  always @(posedge clk)
    if (rst && b.req && b.ack && b.we) wr_cnt <= wr_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0;
    if_ce_i = 1'b0; if_addr_i = 32'h0; if_hold_i = 1'b0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_sel_i = 4'h0;
    mem_wdata_i = 32'h0; mem_hold_i = 1'b0;
    b.ack = 1'b0; b.rdata = 32'h0;
    tick(); tick();
    chk("rst_req",   {31'h0, b.req}, 32'h0);
    chk("rst_we",    {31'h0, b.we}, 32'h0);
    chk("rst_addr",  b.addr, 32'h0);
    chk("rst_sel",   {28'h0, b.sel}, 32'h0);
    chk("rst_wdata", b.wdata, 32'h0);
    chk("rst_tmo",   {31'h0, b.timeout}, 32'h0);
    chk("rst_ifd",   if_data_o, 32'h0);
    chk("rst_memd",  mem_rdata_o, 32'h0);
    rst = 1'b1;
    tick();

    // 1: IF-only fetch, ack on the 2nd request cycle
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0100; if_hold_i = 1'b1;
    #1 chk("t1_stall0", {31'h0, if_stallreq_o}, 32'h1);
    tick();
    chk("t1_req1", {31'h0, b.req}, 32'h1);
    chk("t1_addr", b.addr, 32'h0000_0100);
    chk("t1_sel",  {28'h0, b.sel}, 32'hF);
    chk("t1_we",   {31'h0, b.we}, 32'h0);
    tick();
    chk("t1_req2", {31'h0, b.req}, 32'h1);
    b.ack = 1'b1; b.rdata = 32'h2402_0005;
    tick();
    b.ack = 1'b0;
    chk("t1_req_off", {31'h0, b.req}, 32'h0);
    chk("t1_data",    if_data_o, 32'h2402_0005);
    chk("t1_stall",   {31'h0, if_stallreq_o}, 32'h0);
    if_ce_i = 1'b0; if_hold_i = 1'b0;
    tick();

    // 2: simultaneous IF + MEM load, zero-wait bus
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0200; if_hold_i = 1'b1;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000_0010; mem_sel_i = 4'b0011;
    mem_hold_i = 1'b1;
    tick();
    chk("t2_req_mem", {31'h0, b.req}, 32'h1);
    chk("t2_addr_mem", b.addr, 32'h8000_0010);
    chk("t2_sel_mem", {28'h0, b.sel}, 32'h3);
    b.ack = 1'b1; b.rdata = 32'hCAFE_0011;
    tick();
    b.ack = 1'b0;
    chk("t2_memd",       mem_rdata_o, 32'hCAFE_0011);
    chk("t2_mstall_c2",  {31'h0, mem_stallreq_o}, 32'h0);
    chk("t2_istall_c2",  {31'h0, if_stallreq_o}, 32'h1);
    chk("t2_req_gap",    {31'h0, b.req}, 32'h0);
    tick();
    chk("t2_req_if",  {31'h0, b.req}, 32'h1);
    chk("t2_addr_if", b.addr, 32'h0000_0200);
    chk("t2_sel_if",  {28'h0, b.sel}, 32'hF);
    chk("t2_istall_c3", {31'h0, if_stallreq_o}, 32'h1);
    b.ack = 1'b1; b.rdata = 32'h0002_00AB;
    tick();
    b.ack = 1'b0;
    chk("t2_ifd",       if_data_o, 32'h0002_00AB);
    chk("t2_istall_c4", {31'h0, if_stallreq_o}, 32'h0);
    if_ce_i = 1'b0; if_hold_i = 1'b0; mem_ce_i = 1'b0; mem_hold_i = 1'b0;
    tick();

    // 3: store held for 3 cycles after ack must hit the bus once
    wr0 = wr_cnt;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8000_0020;
    mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'hF; mem_hold_i = 1'b1;
    tick();
    chk("t3_req",   {31'h0, b.req}, 32'h1);
    chk("t3_we",    {31'h0, b.we}, 32'h1);
    chk("t3_wdata", b.wdata, 32'hDEAD_BEEF);
    b.ack = 1'b1; b.rdata = 32'h5555_5555;
    tick();
    b.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_stall", {31'h0, mem_stallreq_o}, 32'h0);
      chk("t3_hold_req",   {31'h0, b.req}, 32'h0);
      tick();
    end
    mem_ce_i = 1'b0; mem_hold_i = 1'b0; mem_we_i = 1'b0;
    tick();
    chk("t3_writes", wr_cnt - wr0, 32'd1);
    chk("t3_memd_keep", mem_rdata_o, 32'hCAFE_0011);

    // 4: flush during a fetch drains the bus and discards the data
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0300; if_hold_i = 1'b1;
    tick();
    chk("t4_req", {31'h0, b.req}, 32'h1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; if_ce_i = 1'b0; if_hold_i = 1'b0;
    chk("t4_drain_c2", {31'h0, b.req}, 32'h1);
    tick();
    chk("t4_drain_c3", {31'h0, b.req}, 32'h1);
    chk("t4_addr_hold", b.addr, 32'h0000_0300);
    tick();
    chk("t4_drain_c4", {31'h0, b.req}, 32'h1);
    b.ack = 1'b1; b.rdata = 32'h1234_5678;
    tick();
    b.ack = 1'b0;
    chk("t4_req_off", {31'h0, b.req}, 32'h0);
    chk("t4_ifd_keep", if_data_o, 32'h0002_00AB);
    tick();
    chk("t4_idle", {31'h0, b.req}, 32'h0);

    // 5: load never acked -> abort after 8 request cycles
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000_0040; mem_sel_i = 4'hF;
    mem_hold_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_req_wait", {31'h0, b.req}, 32'h1);
      chk("t5_tmo_low",  {31'h0, b.timeout}, 32'h0);
    end
    tick();
    chk("t5_tmo_pulse", {31'h0, b.timeout}, 32'h1);
    chk("t5_req_off",   {31'h0, b.req}, 32'h0);
    chk("t5_memd",      mem_rdata_o, 32'h0);
    chk("t5_stall",     {31'h0, mem_stallreq_o}, 32'h0);
    tick();
    chk("t5_tmo_one", {31'h0, b.timeout}, 32'h0);
    mem_ce_i = 1'b0; mem_hold_i = 1'b0;
    tick();

    // 6: reset in the middle of a data access, then a late ack
    mem_ce_i = 1'b1; mem_addr_i = 32'h8000_0050; mem_sel_i = 4'h3; mem_hold_i = 1'b1;
    tick();
    chk("t6_req", {31'h0, b.req}, 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1; mem_ce_i = 1'b0; mem_hold_i = 1'b0;
    chk("t6_req_rst",  {31'h0, b.req}, 32'h0);
    chk("t6_addr_rst", b.addr, 32'h0);
    chk("t6_sel_rst",  {28'h0, b.sel}, 32'h0);
    chk("t6_ifd_rst",  if_data_o, 32'h0);
    chk("t6_memd_rst", mem_rdata_o, 32'h0);
    b.ack = 1'b1; b.rdata = 32'h0BAD_0BAD;
    tick();
    b.ack = 1'b0;
    chk("t6_late_req",  {31'h0, b.req}, 32'h0);
    chk("t6_late_memd", mem_rdata_o, 32'h0);
    chk("t6_late_stall", {31'h0, mem_stallreq_o}, 32'h0);
    tick();
    chk("t6_still_idle", {31'h0, b.req}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
